// File: rtl/apb4_master_bridge.sv
// apb4_master_bridge: valid/ready command stream to APB4 requester, one transfer outstanding.
// Optional ACCESS-phase watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb4_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [2:0]              PPROT,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3;
  logic [1:0] state;
  logic accept, expire;
  assign cmd_ready = !PRESET && (state == IDLE || (state == RESP && rsp_ready));
  assign accept    = cmd_valid && cmd_ready;
  assign PSEL      = state == SETUP || state == ACCESS;
  assign PENABLE   = state == ACCESS;
  assign rsp_valid = state == RESP;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge PCLK)
    if (state == SETUP) cnt <= '0;
    else if (state == ACCESS && !PREADY) cnt <= cnt + 1'b1;
  // cnt holds the number of completed wait cycles, so this is the last allowed one
  assign expire = state == ACCESS && !PREADY && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign expire = 1'b0;
`endif
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      PPROT       <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (accept) begin
      state  <= SETUP;
      PADDR  <= cmd_addr;
      PWRITE <= cmd_write;
      PPROT  <= cmd_prot;
      PWDATA <= cmd_write ? cmd_wdata : '0;
      PSTRB  <= cmd_write ? cmd_strb : '0;
    end else if (state == SETUP) begin
      state <= ACCESS;
    end else if (state == ACCESS && (PREADY || expire)) begin
      state       <= RESP;
      rsp_rdata   <= (PWRITE || !PREADY) ? '0 : PRDATA;
      rsp_slverr  <= PREADY ? PSLVERR : 1'b1;
      rsp_timeout <= !PREADY;
    end else if (state == RESP && rsp_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_apb4_master_bridge.sv
// tb_apb4_master_bridge: directed self-checking bench for apb4_master_bridge.
module tb_apb4_master_bridge;
  logic        PCLK = 0, PRESET = 1;
  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0]  cmd_strb = 0;
  logic [2:0]  cmd_prot = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA = 0;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        PREADY = 0, PSLVERR = 0;
  int total = 0, bad = 0;

  apb4_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR));

  always #5 PCLK = ~PCLK;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = 4'hF;
  endtask

  task automatic test_reset();
    PRESET = 1;
    step(); step();
    total++; if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_slverr, rsp_timeout, cmd_ready} !== 7'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=0", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_slverr, rsp_timeout, cmd_ready}); end
    total++; if ({PADDR, PWDATA, PSTRB, PPROT, rsp_rdata} !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", {PADDR, PWDATA, PSTRB, PPROT, rsp_rdata}); end
    PRESET = 0;
    step();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write();
    PREADY = 1; PRDATA = 32'hFFFF_FFFF; cmd_prot = 3'b010;
    issue(1, 32'h10, 32'hDEAD_BEEF);
    step(); cmd_valid = 0;
    total++; if ({PSEL, PENABLE, PWRITE} !== 3'b101) begin bad++; $display("FAIL wr_setup_ctrl got=%b exp=101", {PSEL, PENABLE, PWRITE}); end
    total++; if ({PADDR, PWDATA, PSTRB, PPROT} !== {32'h10, 32'hDEAD_BEEF, 4'hF, 3'b010}) begin bad++; $display("FAIL wr_setup_bus got=%h %h %h %h", PADDR, PWDATA, PSTRB, PPROT); end
    step();
    total++; if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin bad++; $display("FAIL wr_access got=%b exp=110", {PSEL, PENABLE, rsp_valid}); end
    step();
    total++; if ({PSEL, rsp_valid, rsp_slverr, rsp_timeout} !== 4'b0100) begin bad++; $display("FAIL wr_resp got=%b exp=0100", {PSEL, rsp_valid, rsp_slverr, rsp_timeout}); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL wr_rdata got=%h exp=0", rsp_rdata); end
    rsp_ready = 1;
    step(); rsp_ready = 0;
    total++; if ({rsp_valid, cmd_ready} !== 2'b01) begin bad++; $display("FAIL wr_idle got=%b exp=01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_read_wait();
    int acc = 0;
    PREADY = 0; PRDATA = 0;
    issue(0, 32'h20, 32'hAAAA_5555);
    step(); cmd_valid = 0;
    total++; if ({PWRITE, PSTRB, PWDATA, PADDR} !== {1'b0, 4'h0, 32'h0, 32'h20}) begin bad++; $display("FAIL rd_setup got=%b %h %h %h", PWRITE, PSTRB, PWDATA, PADDR); end
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin PREADY = 1; PRDATA = 32'h1234_5678; end
      if (PENABLE === 1'b1) acc++;
      total++; if ({PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA} !== {3'b110, 32'h20, 4'h0, 32'h0}) begin bad++; $display("FAIL rd_stable cyc=%0d got=%b%b%b %h %h %h", i, PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA); end
      step();
    end
    total++; if (acc !== 4 || PENABLE !== 1'b0) begin bad++; $display("FAIL rd_access_len got=%0d/%b exp=4/0", acc, PENABLE); end
    total++; if ({rsp_valid, rsp_slverr, rsp_rdata} !== {2'b10, 32'h1234_5678}) begin bad++; $display("FAIL rd_resp got=%b%b %h exp=10 12345678", rsp_valid, rsp_slverr, rsp_rdata); end
    rsp_ready = 1; step(); rsp_ready = 0;
  endtask

  task automatic test_back_to_back();
    PREADY = 1; rsp_ready = 1;
    issue(1, 32'h30, 32'h1);
    step();
    issue(1, 32'h34, 32'h2);
    total++; if ({PSEL, PADDR, cmd_ready} !== {1'b1, 32'h30, 1'b0}) begin bad++; $display("FAIL b2b_setup1 got=%b %h %b", PSEL, PADDR, cmd_ready); end
    step(); step();
    total++; if ({rsp_valid, PSEL, cmd_ready} !== 3'b101) begin bad++; $display("FAIL b2b_resp1 got=%b exp=101", {rsp_valid, PSEL, cmd_ready}); end
    step(); cmd_valid = 0;
    total++; if ({PSEL, PENABLE, PADDR, PWDATA, rsp_valid} !== {2'b10, 32'h34, 32'h2, 1'b0}) begin bad++; $display("FAIL b2b_setup2 got=%b%b %h %h %b", PSEL, PENABLE, PADDR, PWDATA, rsp_valid); end
    step(); step();
    total++; if ({rsp_valid, PSEL, PADDR} !== {2'b10, 32'h34}) begin bad++; $display("FAIL b2b_resp2 got=%b%b %h", rsp_valid, PSEL, PADDR); end
    step();
    total++; if ({rsp_valid, PSEL, cmd_ready} !== 3'b001) begin bad++; $display("FAIL b2b_idle got=%b exp=001", {rsp_valid, PSEL, cmd_ready}); end
    rsp_ready = 0;
  endtask

  task automatic test_slverr();
    PREADY = 0; PSLVERR = 1;
    issue(0, 32'h40, 32'h0);
    step(); cmd_valid = 0;
    step(); step(); step();
    total++; if ({rsp_valid, PENABLE} !== 2'b01) begin bad++; $display("FAIL err_wait got=%b exp=01", {rsp_valid, PENABLE}); end
    PREADY = 1; PSLVERR = 0; PRDATA = 32'h77;
    step();
    total++; if ({rsp_valid, rsp_slverr, rsp_rdata} !== {2'b10, 32'h77}) begin bad++; $display("FAIL err_ignored got=%b%b %h exp=10 77", rsp_valid, rsp_slverr, rsp_rdata); end
    rsp_ready = 1; step(); rsp_ready = 0;
    PSLVERR = 1; PRDATA = 32'hCAFE_F00D;
    issue(0, 32'h44, 32'h0);
    step(); cmd_valid = 0;
    step(); step();
    PSLVERR = 0; PREADY = 0;
    total++; if ({rsp_valid, rsp_slverr, rsp_rdata} !== {2'b11, 32'hCAFE_F00D}) begin bad++; $display("FAIL err_taken got=%b%b %h exp=11 cafef00d", rsp_valid, rsp_slverr, rsp_rdata); end
  endtask

  task automatic test_hold_and_reset();
    issue(1, 32'h50, 32'h5);
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if ({rsp_valid, rsp_slverr, rsp_rdata, cmd_ready, PSEL} !== {2'b11, 32'hCAFE_F00D, 2'b00}) begin bad++; $display("FAIL hold cyc=%0d got=%b%b %h %b%b", i, rsp_valid, rsp_slverr, rsp_rdata, cmd_ready, PSEL); end
    end
    rsp_ready = 1;
    step(); rsp_ready = 0;
    total++; if ({PSEL, PADDR, rsp_valid} !== {1'b1, 32'h50, 1'b0}) begin bad++; $display("FAIL hold_release got=%b %h %b", PSEL, PADDR, rsp_valid); end
    cmd_valid = 0;
    step();
    total++; if ({PSEL, PENABLE} !== 2'b11) begin bad++; $display("FAIL mid_access got=%b exp=11", {PSEL, PENABLE}); end
    PRESET = 1;
    step();
    total++; if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0000) begin bad++; $display("FAIL mid_reset got=%b exp=0000", {PSEL, PENABLE, rsp_valid, cmd_ready}); end
    PRESET = 0;
    step(); step();
    total++; if ({PSEL, rsp_valid, cmd_ready} !== 3'b001) begin bad++; $display("FAIL post_reset got=%b exp=001", {PSEL, rsp_valid, cmd_ready}); end
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int acc = 0;
    PREADY = 0; PRDATA = 32'h99;
    issue(0, 32'h60, 32'h0);
    step(); cmd_valid = 0;
    step();
    for (int i = 0; i < 10 && PENABLE === 1'b1; i++) begin acc++; step(); end
    total++; if ({acc, rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata, PSEL} !== {32'd8, 3'b111, 32'h0, 1'b0}) begin bad++; $display("FAIL timeout got=%0d %b%b%b %h %b exp=8 111 0 0", acc, rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata, PSEL); end
    rsp_ready = 1; step(); rsp_ready = 0;
    issue(0, 32'h64, 32'h0);
    step(); cmd_valid = 0;
    step();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin PREADY = 1; PRDATA = 32'h55; end
      step();
    end
    total++; if ({rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata} !== {3'b100, 32'h55}) begin bad++; $display("FAIL timeout_late_ready got=%b%b%b %h exp=100 55", rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata); end
    rsp_ready = 1; step(); rsp_ready = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_slverr();
    test_hold_and_reset();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb4_master_bridge.md
# apb4_master_bridge

APB4 requester (master) that converts a simple valid/ready command stream into APB4 SETUP/ACCESS transfers and returns each result on a valid/ready response stream. It drives the bus that the APB4 slave VIP responds to, and serves as the RTL initiator for DUT-side integration and loop-back testing of that VIP. Only one transfer is outstanding at a time.

## Interface
- ADDR_WIDTH, 32, PADDR/cmd_addr width
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be 8, 16 or 32
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase length; must be >= 2; used only with the timeout feature
- Reset polarity and timing: one clock; reset is synchronous and active-high.
- PCLK  in  1  clock, all logic on the rising edge
- PRESET  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte strobes
- cmd_prot  in  3  PPROT value
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high together with rsp_valid
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_slverr  out  1  slave error or timeout
- rsp_timeout  out  1  transfer aborted by watchdog
- PSEL, PENABLE, PWRITE  out  1 each  APB4 control
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH; PSTRB  out  DATA_WIDTH/8; PPROT  out  3
- PRDATA  in  DATA_WIDTH; PREADY  in  1; PSLVERR  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- cmd_ready = !PRESET && (state==IDLE || (state==RESP && rsp_ready)).
- Accept: cmd fields are registered; the next state is SETUP.
- SETUP, exactly 1 cycle: PSEL=1, PENABLE=0, with PADDR/PWRITE/PPROT/PWDATA/PSTRB taken from the registered command. The next state is ACCESS.
- ACCESS: PSEL=1, PENABLE=1, and all bus outputs are held stable.
  - PREADY=1 at an edge completes the transfer. On a read, PRDATA is captured into rsp_rdata (it is 0 on a write), PSLVERR is captured into rsp_slverr, and the next state is RESP.
  - PSLVERR is ignored while PREADY=0.
- RESP: PSEL=0, PENABLE=0, rsp_valid=1, and the response fields are held stable.
  - rsp_ready=1 with no new command leads to IDLE.
  - rsp_ready=1 with cmd_valid=1 accepts the new command and goes to SETUP directly.
- Reads drive PSTRB=0 and PWDATA=0, as APB4 requires.
- Between transfers, PADDR, PWRITE and PPROT hold their last values, and PSTRB/PWDATA hold their last values.
- Reset values: PSEL 0, PENABLE 0, PWRITE 0, PADDR 0, PWDATA 0, PSTRB 0, PPROT 0, rsp_valid 0, rsp_rdata 0, rsp_slverr 0, rsp_timeout 0, cmd_ready 0.
- Reset mid-transfer: at the next edge the state is IDLE, PSEL/PENABLE are 0, and any in-flight transfer or pending response is discarded with no response issued.

## Timing
- Accept edge N: SETUP during cycle N+1, ACCESS from N+2.
- PREADY at edge M: rsp_valid is high from cycle M+1.
- Minimum bus occupancy is 2 cycles per transfer.
- Minimum issue-to-issue period is 3 cycles, with PSEL low for exactly 1 cycle between back-to-back transfers.
- No combinational path from any APB input to any APB output.
- cmd_ready depends combinationally on rsp_ready only.

## Configuration
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - If PREADY is still 0 at the end of the TIMEOUT_CYCLES-th ACCESS cycle, the transfer ends and the next state is RESP with rsp_slverr=1, rsp_timeout=1 and rsp_rdata=0. PSEL/PENABLE drop at the same edge.
  - PREADY=1 in the expiry cycle takes priority and the transfer completes normally.
- Undefined:
  - No counter is built and ACCESS waits indefinitely.
  - rsp_timeout is tied to 0 and TIMEOUT_CYCLES is ignored.

## Test plan
- Write, addr 0x10, data 0xDEADBEEF, strb 0xF, PREADY tied 1 -> PSEL rises 1 cycle after accept, PENABLE 1 cycle later, rsp_valid 1 cycle after that with rsp_slverr=0 and rsp_rdata=0.
- Read, addr 0x20, slave holds PREADY=0 for 3 cycles then PRDATA=0x12345678 -> ACCESS lasts 4 cycles with bus signals stable throughout, PSTRB=0, rsp_rdata=0x12345678.
- Two writes queued, rsp_ready=1 -> the second SETUP starts in the cycle after the first RESP, PSEL is low for exactly 1 cycle between them, and two responses arrive in order.
- PSLVERR=1 with PREADY=0 for 2 cycles, then PSLVERR=0 with PREADY=1 -> rsp_slverr=0. Repeat with PSLVERR=1 while PREADY=1 -> rsp_slverr=1.
- rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_slverr stay stable, cmd_ready=0 and PSEL=0. Then assert PRESET mid-ACCESS -> PSEL=0 and rsp_valid=0 at the next edge.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, PREADY never asserted -> ACCESS lasts exactly 8 cycles, then rsp_slverr=1 and rsp_timeout=1. PREADY=1 in cycle 8 -> normal completion with rsp_timeout=0.
